// File: rtl/qnm_pkg.sv
// Shared qnm constants: entry field layout, drain FSM encoding,
// and the tag value that marks an entry as ready.
package qnm_pkg;

  localparam int READY_TAG = 0;
  localparam int M_LSB     = 0;
  localparam int CNT_W     = 16;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_HOLD = 1'b1
  } state_e;

  // N field sits directly above the M field
  function automatic int n_lsb(input int m_width);
    return M_LSB + m_width;
  endfunction

endpackage

// File: rtl/qnm_wake_match.sv
// Per-slot wakeup comparator: flags every slot whose pending tag
// equals the broadcast tag, except a slot being written this cycle.
module qnm_wake_match
  import qnm_pkg::*;
#(
  parameter int M_WIDTH  = 8,
  parameter int Q_LENGTH = 8
) (
  input  logic                         wake_valid_i,
  input  logic [M_WIDTH-1:0]           wake_tag_i,
  input  logic [M_WIDTH*Q_LENGTH-1:0]  old_m_i,
  input  logic [Q_LENGTH-1:0]          wr_onehot_i,
  output logic [Q_LENGTH-1:0]          modify_o
);

  logic arm;

  assign arm = wake_valid_i &
               (wake_tag_i != M_WIDTH'(READY_TAG));

  always_comb begin
    modify_o = '0;
    for (int k = 0; k < Q_LENGTH; k++) begin
      modify_o[k] = arm &
        (old_m_i[k*M_WIDTH +: M_WIDTH] == wake_tag_i) &
        !wr_onehot_i[k];
    end
  end

endmodule

// File: rtl/qnm_drain.sv
// Reader-side controller for the qnm queue: pops ready heads onto a
// valid/ready request port and clears woken tags in place.
module qnm_drain
  import qnm_pkg::*;
#(
  parameter int N_WIDTH   = 8,
  parameter int M_WIDTH   = 8,
  parameter int Q_LENGTH  = 8,
  parameter int STALL_MAX = 255
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        q_empty,
  input  logic [N_WIDTH+M_WIDTH-1:0]  q_dout,
  input  logic [M_WIDTH*Q_LENGTH-1:0] q_old_m_vector,
  input  logic [Q_LENGTH-1:0]         q_wr_onehot,
  output logic                        q_rd,
  output logic [Q_LENGTH-1:0]         q_modify_vector,
  output logic [M_WIDTH*Q_LENGTH-1:0] q_new_m_vector,
  input  logic                        wake_valid,
  input  logic [M_WIDTH-1:0]          wake_tag,
  output logic                        req_valid,
  input  logic                        req_ready,
  output logic [N_WIDTH-1:0]          req_n,
  output logic                        stall_err
);

  localparam int N_LSB = n_lsb(M_WIDTH);
  localparam logic [CNT_W-1:0] STALL_LIM = CNT_W'(STALL_MAX);
  localparam logic [CNT_W-1:0] CNT_SAT   = '1;

  state_e             state_q, state_d;
  logic [N_WIDTH-1:0] n_q, n_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               err_q, err_d;

  logic [M_WIDTH-1:0] head_m;
  logic [N_WIDTH-1:0] head_n;
  logic               head_ready;
  logic               slot_free;

  assign head_m = q_dout[M_LSB +: M_WIDTH];
  assign head_n = q_dout[N_LSB +: N_WIDTH];

  assign head_ready = !q_empty &
                      (head_m == M_WIDTH'(READY_TAG));
  assign req_valid  = (state_q == ST_HOLD);
  assign slot_free  = !req_valid | req_ready;
  assign q_rd       = !rst & head_ready & slot_free;

  assign req_n          = n_q;
  assign stall_err      = err_q;
  assign q_new_m_vector = '0;

  qnm_wake_match #(
    .M_WIDTH  (M_WIDTH),
    .Q_LENGTH (Q_LENGTH)
  ) u_match (
    .wake_valid_i (wake_valid & !rst),
    .wake_tag_i   (wake_tag),
    .old_m_i      (q_old_m_vector),
    .wr_onehot_i  (q_wr_onehot),
    .modify_o     (q_modify_vector)
  );

  always_comb begin
    state_d = state_q;
    n_d     = n_q;
    unique case (state_q)
      ST_IDLE: begin
        if (q_rd) begin
          state_d = ST_HOLD;
          n_d     = head_n;
        end
      end
      ST_HOLD: begin
        if (req_ready) begin
          if (q_rd) n_d = head_n;
          else      state_d = ST_IDLE;
        end
      end
    endcase
  end

  // a ready head held off by back-pressure keeps the count frozen
  always_comb begin
    cnt_d = cnt_q;
    if (q_empty | q_rd)
      cnt_d = '0;
    else if (!head_ready && cnt_q != CNT_SAT)
      cnt_d = cnt_q + 1'b1;
    err_d = err_q | (cnt_d == STALL_LIM);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      n_q     <= '0;
      cnt_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      n_q     <= n_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
    end
  end

endmodule

// File: tb/tb_qnm_drain.sv
// Bench for qnm_drain: plays the qnm queue, predicts every output
// from a cycle-level model and runs directed plus random traffic.
module tb_qnm_drain;

  localparam int NW = 8;
  localparam int MW = 8;
  localparam int QL = 8;
  localparam int SM = 4;

  logic           clk = 1'b0;
  logic           rst = 1'b1;
  logic           q_empty = 1'b1;
  logic [NW+MW-1:0] q_dout = '0;
  logic [MW*QL-1:0] q_old_m_vector = '0;
  logic [QL-1:0]  q_wr_onehot = '0;
  logic           q_rd;
  logic [QL-1:0]  q_modify_vector;
  logic [MW*QL-1:0] q_new_m_vector;
  logic           wake_valid = 1'b0;
  logic [MW-1:0]  wake_tag = '0;
  logic           req_valid;
  logic           req_ready = 1'b0;
  logic [NW-1:0]  req_n;
  logic           stall_err;

  qnm_drain #(
    .N_WIDTH(NW), .M_WIDTH(MW), .Q_LENGTH(QL), .STALL_MAX(SM)
  ) dut (
    .clk(clk), .rst(rst), .q_empty(q_empty), .q_dout(q_dout),
    .q_old_m_vector(q_old_m_vector), .q_wr_onehot(q_wr_onehot),
    .q_rd(q_rd), .q_modify_vector(q_modify_vector),
    .q_new_m_vector(q_new_m_vector), .wake_valid(wake_valid),
    .wake_tag(wake_tag), .req_valid(req_valid),
    .req_ready(req_ready), .req_n(req_n), .stall_err(stall_err)
  );

  always #5 clk = ~clk;

  // queue contents (the bench is the qnm)
  logic [7:0] qn [QL];
  logic [7:0] qm [QL];
  int rd_p, wr_p, qcount;

  // expected drain behaviour
  bit         exp_valid;
  logic [7:0] exp_n;
  int         scnt;
  bit         exp_err;

  int checks = 0;
  int failures = 0;

  logic       obs_rd, obs_valid, obs_err;
  logic [7:0] obs_n, obs_mod;
  logic [7:0] acc_q [$];
  int         nrd;
  int         hs;

  task automatic chk(input string tag, input logic [63:0] got,
                     input logic [63:0] exp);
    checks++;
    assert (got === exp) else begin
      failures++;
      $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic reset_q();
    rd_p = 0;
    wr_p = 0;
    qcount = 0;
  endtask

  task automatic step(input bit push, input logic [7:0] pn,
                      input logic [7:0] pm, input bit wv,
                      input logic [7:0] wt, input bit rdy);
    logic [7:0]  wr1h, mexp;
    logic [63:0] oldm;
    bit hr, pop;
    for (int k = 0; k < QL; k++) oldm[k*8 +: 8] = qm[k];
    wr1h = (!rst && push && qcount < QL) ? 8'(1 << wr_p) : 8'h00;
    q_empty = (qcount == 0);
    q_dout = {qn[rd_p], qm[rd_p]};
    q_old_m_vector = oldm;
    q_wr_onehot = wr1h;
    wake_valid = wv;
    wake_tag = wt;
    req_ready = rdy;
    if (rst) begin
      exp_valid = 0;
      exp_n = '0;
      scnt = 0;
      exp_err = 0;
    end
    hr = !rst && qcount > 0 && qm[rd_p] == 8'h00;
    pop = hr && (!exp_valid || rdy);
    for (int k = 0; k < QL; k++)
      mexp[k] = !rst && wv && wt != 0 && qm[k] == wt && !wr1h[k];
    @(negedge clk);
    #1;
    chk("q_rd", 64'(q_rd), 64'(pop));
    chk("modify", 64'(q_modify_vector), 64'(mexp));
    chk("new_m", q_new_m_vector, 64'h0);
    chk("req_valid", 64'(req_valid), 64'(exp_valid));
    chk("req_n", 64'(req_n), 64'(exp_n));
    chk("stall_err", 64'(stall_err), 64'(exp_err));
    obs_rd = q_rd;
    obs_valid = req_valid;
    obs_n = req_n;
    obs_err = stall_err;
    obs_mod = q_modify_vector;
    if (req_valid === 1'b1 && rdy) acc_q.push_back(req_n);
    if (q_rd === 1'b1) nrd++;
    @(posedge clk);
    if (!rst) begin
      if (qcount == 0 || pop) scnt = 0;
      else if (!hr && scnt < 65535) scnt++;
      if (scnt == SM) exp_err = 1;
      if (pop) begin
        exp_valid = 1;
        exp_n = qn[rd_p];
      end else if (rdy) begin
        exp_valid = 0;
      end
      for (int k = 0; k < QL; k++) if (mexp[k]) qm[k] = 8'h00;
      if (pop) begin
        rd_p = (rd_p + 1) % QL;
        qcount--;
      end
      if (wr1h != 0) begin
        qn[wr_p] = pn;
        qm[wr_p] = pm;
        wr_p = (wr_p + 1) % QL;
        qcount++;
      end
    end
    #1;
  endtask

  task automatic idle(input bit rdy);
    step(0, 8'h00, 8'h00, 0, 8'h00, rdy);
  endtask

  initial begin
    for (int k = 0; k < QL; k++) begin
      qn[k] = 8'h00;
      qm[k] = 8'hFF;
    end
    reset_q();

    // reset with a ready entry already queued
    rst = 1;
    qn[0] = 8'h12;
    qm[0] = 8'h00;
    qcount = 1;
    wr_p = 1;
    idle(1);
    chk("rst_rd", 64'(obs_rd), 64'h0);
    chk("rst_valid", 64'(obs_valid), 64'h0);
    idle(1);
    rst = 0;
    idle(0);
    chk("rel_rd", 64'(obs_rd), 64'h1);
    idle(0);
    chk("rel_valid", 64'(obs_valid), 64'h1);
    chk("rel_n", 64'(obs_n), 64'h12);

    // three ready entries, downstream always ready
    step(1, 8'hA1, 8'h00, 0, 8'h00, 1);
    acc_q.delete();
    nrd = 0;
    step(1, 8'hA2, 8'h00, 0, 8'h00, 1);
    step(1, 8'hA3, 8'h00, 0, 8'h00, 1);
    idle(1);
    chk("burst_rd", 64'(nrd), 64'd3);
    idle(1);
    idle(1);
    chk("burst_drop", 64'(obs_valid), 64'h0);
    chk("burst_cnt", 64'(acc_q.size()), 64'd3);
    if (acc_q.size() == 3) begin
      chk("burst_n0", 64'(acc_q[0]), 64'hA1);
      chk("burst_n1", 64'(acc_q[1]), 64'hA2);
      chk("burst_n2", 64'(acc_q[2]), 64'hA3);
    end

    // blocked head released by a wakeup
    hs = wr_p;
    step(1, 8'h40, 8'h05, 0, 8'h00, 1);
    idle(1);
    chk("wake_pre_rd", 64'(obs_rd), 64'h0);
    step(0, 8'h00, 8'h00, 1, 8'h05, 1);
    chk("wake_mod", 64'(obs_mod[hs]), 64'h1);
    idle(1);
    chk("wake_rd", 64'(obs_rd), 64'h1);
    idle(0);
    chk("wake_valid", 64'(obs_valid), 64'h1);
    chk("wake_n", 64'(obs_n), 64'h40);
    idle(1);
    idle(1);

    // stall detection plus write-suppressed wakeup
    rst = 1;
    reset_q();
    for (int k = 0; k < QL; k++) qm[k] = 8'hEE;
    qm[5] = 8'h07;
    idle(1);
    rst = 0;
    step(1, 8'hB0, 8'h03, 0, 8'h00, 1);
    step(1, 8'hB1, 8'h01, 0, 8'h00, 1);
    step(1, 8'hB2, 8'h07, 0, 8'h00, 1);
    step(1, 8'hB3, 8'h01, 0, 8'h00, 1);
    step(1, 8'hB4, 8'h01, 0, 8'h00, 1);
    chk("stall_pre", 64'(obs_err), 64'h0);
    step(1, 8'hB5, 8'h02, 1, 8'h07, 1);
    chk("wr_suppress", 64'(obs_mod), 64'h04);
    chk("stall_set", 64'(obs_err), 64'h1);
    step(0, 8'h00, 8'h00, 1, 8'h00, 1);
    chk("tag_zero", 64'(obs_mod), 64'h00);
    step(0, 8'h00, 8'h00, 1, 8'h03, 1);
    step(0, 8'h00, 8'h00, 1, 8'h01, 1);
    step(0, 8'h00, 8'h00, 1, 8'h02, 1);
    for (int i = 0; i < 8; i++) idle(1);
    chk("stall_sticky", 64'(obs_err), 64'h1);
    rst = 1;
    reset_q();
    idle(1);
    chk("stall_rst", 64'(obs_err), 64'h0);
    rst = 0;

    // back-pressure with ready entries waiting
    step(1, 8'hC0, 8'h00, 0, 8'h00, 0);
    step(1, 8'hC1, 8'h00, 0, 8'h00, 0);
    step(1, 8'hC2, 8'h00, 0, 8'h00, 0);
    step(1, 8'hC3, 8'h00, 0, 8'h00, 0);
    nrd = 0;
    for (int i = 0; i < 10; i++) idle(0);
    chk("bp_rd", 64'(nrd), 64'd0);
    chk("bp_n", 64'(obs_n), 64'hC0);
    idle(1);
    chk("bp_release", 64'(obs_rd), 64'h1);
    idle(1);
    chk("bp_next", 64'(obs_n), 64'hC1);
    for (int i = 0; i < 4; i++) idle(1);

    // random traffic
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(0, 149) == 0) begin
        rst = 1;
        reset_q();
        idle(1);
        rst = 0;
      end else begin
        step($urandom_range(0, 2) != 0,
             8'($urandom),
             8'($urandom_range(0, 3)),
             $urandom_range(0, 1) == 1,
             8'($urandom_range(0, 3)),
             $urandom_range(0, 3) != 0);
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/qnm_drain.md
Name: qnm_drain

Overview:
- Reader-side controller for the qnm miss/request queue.
- Watches the queue head and pops entries whose M field (dependency tag) has cleared. Each popped entry is presented downstream on a valid/ready request port.
- Clears the M field of waiting entries in place through the queue's modify port when a matching wakeup tag is broadcast.
- Sits between the qnm instance and the cache's memory-request arbiter.

Parameters:
- N_WIDTH, 8, width of the N (payload/address) field of a queue entry.
- M_WIDTH, 8, width of the M (dependency tag) field; value 0 means "ready", nonzero is a pending tag.
- Q_LENGTH, 8, number of queue slots; one-hot slot encoding.
- STALL_MAX, 255, head-blocked cycle count at which stall_err sets; fits in 16 bits.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- q_empty  in  1  qnm empty flag.
- q_dout  in  N_WIDTH+M_WIDTH  qnm head entry {n, m}.
- q_old_m_vector  in  M_WIDTH*Q_LENGTH  M field of every slot, slot k at [k*M_WIDTH +: M_WIDTH].
- q_wr_onehot  in  Q_LENGTH  slot being written this cycle (qnm wr & !full & wr_ptr), else 0.
- q_rd  out  1  pop strobe to qnm.
- q_modify_vector  out  Q_LENGTH  per-slot M-field overwrite enable.
- q_new_m_vector  out  M_WIDTH*Q_LENGTH  replacement M values; always 0 here.
- wake_valid  in  1  wakeup broadcast valid.
- wake_tag  in  M_WIDTH  tag being released; 0 is ignored.
- req_valid  out  1  downstream request valid.
- req_ready  in  1  downstream accept.
- req_n  out  N_WIDTH  N field of the issued entry.
- stall_err  out  1  sticky, head blocked for STALL_MAX consecutive cycles.

Behaviour:
- Reset (async, immediate): req_valid=0, req_n=0, q_rd=0, q_modify_vector=0, stall_err=0, stall counter=0, FSM=IDLE.
- Definitions:
  - head_ready = !q_empty & (q_dout[M_WIDTH-1:0]==0).
  - slot_free = !req_valid | (req_valid & req_ready).
- FSM states: IDLE, HOLD.
  - IDLE: req_valid=0. If head_ready, the block combinationally asserts q_rd for that cycle, registers req_n<=q_dout n-field and req_valid<=1, and moves to HOLD.
  - HOLD: req_valid=1 and req_n is stable until req_ready.
    - On req_ready & head_ready: back-to-back issue in the same cycle (pop, reload req_n, stay in HOLD).
    - On req_ready & !head_ready: req_valid<=0, go to IDLE.
- q_rd is combinational and never asserted when q_empty. At most one pop per cycle. Throughput is 1 entry/cycle when downstream is always ready.
- Pop-to-valid latency: 1 cycle (pop at cycle t, req_valid high at t+1).
- Wakeup, combinational:
  - For each slot k: q_modify_vector[k] = wake_valid & (wake_tag!=0) & (old_m[k]==wake_tag) & !q_wr_onehot[k].
  - Stale (unoccupied) slots may match. This is harmless because a later write overwrites them.
  - A write to slot k suppresses modify of slot k. Otherwise the queue's modify would overwrite the freshly written entry.
  - A wakeup clearing the head this cycle is seen by head_ready next cycle, so issue follows the wake by 1 cycle.
- Stall counter (16 bit, saturating):
  - Increments each cycle !q_empty & !head_ready.
  - Clears on any pop or when q_empty.
  - stall_err sets when counter==STALL_MAX and stays set until rst.
- Back-pressure while HOLD & !req_ready: no pop. The counter does not run for a ready head.
- Reset mid-HOLD drops req_valid immediately. The popped entry is lost; qnm is reset by the same rst.

Decomposition:
- Shared cache package holds:
  - entry field slicing constants (M field = low M_WIDTH bits, N field = upper N_WIDTH bits);
  - the FSM state encoding;
  - the reserved READY_TAG = 0.
- One sub-module, qnm_wake_match: per-slot tag comparator producing q_modify_vector from q_old_m_vector, wake_valid, wake_tag and q_wr_onehot.

Test Plan:
- Reset with queue holding {n=0x12,m=0} → req_valid=0, q_rd=0 during reset; q_rd=1 the first cycle after release, req_valid=1/req_n=0x12 the next cycle.
- Three ready entries 0xA1,0xA2,0xA3, req_ready held 1 → q_rd high 3 consecutive cycles; req_n sequence A1,A2,A3 on consecutive cycles; then req_valid drops.
- Head {n=0x40,m=0x05}, wake_valid=1/wake_tag=0x05 at cycle t → q_modify_vector bit of head slot=1 at t; q_rd=1 at t+1; req_valid=1, req_n=0x40 at t+2.
- Wake tag 0x07 matches slots 2 and 5 while q_wr_onehot=8'b0010_0000 → q_modify_vector=8'b0000_0100. Wake_tag=0 → q_modify_vector=0.
- req_ready=0 for 10 cycles with ready entries queued → req_n stable, q_rd=0 throughout; first cycle req_ready=1 pops the next entry.
- STALL_MAX=4, head m=0x03 never woken → stall_err=1 after the 4th blocked cycle and stays 1 after a wake until rst.
